// File: rtl/itch_frame_assembler.sv
// Splits a length-prefixed ITCH byte stream into whole messages: 16-bit
// big-endian length, one type byte, then the body packed MSB-first into payload.
module itch_frame_assembler #(
  parameter int MAX_MSG_LEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_byte_valid,
  input  logic [7:0]   in_byte,
  output logic         out_valid,
  output logic [7:0]   msg_type,
  output logic [511:0] payload,
  output logic         frame_err,
  output logic [31:0]  msg_count,
  output logic [15:0]  err_count,
  output logic         busy
);

  localparam logic [2:0] LEN_HI = 3'd0;
  localparam logic [2:0] LEN_LO = 3'd1;
  localparam logic [2:0] TYPE   = 3'd2;
  localparam logic [2:0] BODY   = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  localparam logic [15:0] MAX_LEN = 16'(MAX_MSG_LEN);

  logic [2:0]   state_q,     state_d;
  logic [15:0]  len_q,       len_d;
  logic [15:0]  cnt_q,       cnt_d;
  logic [7:0]   type_q,      type_d;
  logic [511:0] shift_q,     shift_d;
  logic         out_valid_q, out_valid_d;
  logic         frame_err_q, frame_err_d;
  logic [7:0]   msg_type_q,  msg_type_d;
  logic [511:0] payload_q,   payload_d;
  logic [31:0]  msg_count_q, msg_count_d;
  logic [15:0]  err_count_q, err_count_d;

  logic [15:0] len_full;
  logic [15:0] cnt_inc;
  logic [5:0]  body_idx;
  logic [8:0]  bit_hi;

  assign len_full = {len_q[15:8], in_byte};
  assign cnt_inc  = cnt_q + 16'd1;
  // cnt_q counts message bytes consumed so far; the type byte is byte 0.
  assign body_idx = 6'(cnt_q - 16'd1);
  assign bit_hi   = 9'd511 - {body_idx, 3'b000};

  always_comb begin
    // NOTE: every _d starts from a default so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    shift_d     = shift_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;
    msg_type_d  = msg_type_q;
    payload_d   = payload_q;

    if (in_byte_valid) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {in_byte, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = len_full;
          cnt_d = 16'd0;
          if (len_full == 16'd0) begin
            frame_err_d = 1'b1;
            state_d     = LEN_HI;
          end else if (len_full > MAX_LEN) begin
            frame_err_d = 1'b1;
            state_d     = DRAIN;
          end else begin
            state_d = TYPE;
          end
        end
        TYPE: begin
          type_d  = in_byte;
          shift_d = '0;
          cnt_d   = 16'd1;
          if (len_q == 16'd1) begin
            out_valid_d = 1'b1;
            msg_type_d  = in_byte;
            payload_d   = '0;
            state_d     = LEN_HI;
          end else begin
            state_d = BODY;
          end
        end
        BODY: begin
          shift_d[bit_hi -: 8] = in_byte;
          cnt_d                = cnt_inc;
          if (cnt_inc == len_q) begin
            out_valid_d = 1'b1;
            msg_type_d  = type_q;
            payload_d   = shift_d;
            state_d     = LEN_HI;
          end
        end
        DRAIN: begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = LEN_HI;
        end
        default: state_d = LEN_HI;
      endcase
    end

    msg_count_d = out_valid_d ? msg_count_q + 32'd1 : msg_count_q;
    err_count_d = (frame_err_d && err_count_q != 16'hFFFF) ? err_count_q + 16'd1
                                                           : err_count_q;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      cnt_q       <= '0;
      type_q      <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      msg_type_q  <= '0;
      payload_q   <= '0;
      msg_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      type_q      <= type_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      msg_type_q  <= msg_type_d;
      payload_q   <= payload_d;
      msg_count_q <= msg_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign msg_type  = msg_type_q;
  assign payload   = payload_q;
  assign msg_count = msg_count_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != LEN_HI);

endmodule

// File: tb/tb_itch_frame_assembler.sv
// Self-checking bench for itch_frame_assembler: directed frames plus a random
// stream, compared every cycle against a frame-buffer reference model.
module tb_itch_frame_assembler;

  localparam int MAX_LEN = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_byte_valid;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic [7:0]   msg_type;
  logic [511:0] payload;
  logic         frame_err;
  logic [31:0]  msg_count;
  logic [15:0]  err_count;
  logic         busy;

  itch_frame_assembler #(.MAX_MSG_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte_valid(in_byte_valid), .in_byte(in_byte),
    .out_valid(out_valid), .msg_type(msg_type), .payload(payload),
    .frame_err(frame_err), .msg_count(msg_count), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: buffers the current frame's bytes and decides from the
  // whole buffer what the frame means.
  logic [7:0]   frame_buf[$];
  logic [7:0]   tx_q[$];
  logic         exp_ov, exp_fe;
  logic [7:0]   exp_type;
  logic [511:0] exp_payload;
  logic [31:0]  exp_msgs;
  logic [15:0]  exp_errs;
  int           ov_seen, fe_seen;

  task automatic model_reset();
    frame_buf.delete();
    exp_ov = 0; exp_fe = 0;
    exp_type = '0; exp_payload = '0;
    exp_msgs = '0; exp_errs = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int len;
    frame_buf.push_back(b);
    if (frame_buf.size() < 2) return;
    len = {frame_buf[0], frame_buf[1]};
    if (frame_buf.size() == 2 && (len == 0 || len > MAX_LEN)) begin
      exp_fe = 1;
      if (exp_errs != 16'hFFFF) exp_errs++;
      if (len == 0) frame_buf.delete();
      return;
    end
    if (frame_buf.size() == len + 2) begin
      if (len <= MAX_LEN) begin
        exp_ov = 1;
        exp_msgs++;
        exp_type = frame_buf[2];
        exp_payload = '0;
        for (int k = 0; k < len - 1; k++) exp_payload[511 - 8*k -: 8] = frame_buf[3 + k];
      end
      frame_buf.delete();
    end
  endtask

  task automatic step(input logic valid, input logic [7:0] b);
    @(negedge clk);
    in_byte_valid = valid;
    in_byte = valid ? b : 8'($urandom);
    exp_ov = 0; exp_fe = 0;
    if (valid) model_byte(b);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, exp_ov);
    check("frame_err", frame_err, exp_fe);
    check("msg_type", msg_type, exp_type);
    check("payload", payload, exp_payload);
    check("msg_count", msg_count, exp_msgs);
    check("err_count", err_count, exp_errs);
    check("busy", busy, frame_buf.size() != 0);
    if (out_valid) ov_seen++;
    if (frame_err) fe_seen++;
  endtask

  // gap: 0 contiguous, 1 alternate valid/idle, 2 random idles
  task automatic flush(input int gap);
    while (tx_q.size() != 0) begin
      step(1'b1, tx_q.pop_front());
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) step(1'b0, 8'h00);
    end
  endtask

  task automatic queue_frame(input int len, input logic [7:0] typ, input bit counting);
    tx_q.push_back(8'(len >> 8));
    tx_q.push_back(8'(len));
    if (len == 0) return;
    tx_q.push_back(typ);
    for (int k = 1; k < len; k++) tx_q.push_back(counting ? 8'(k) : 8'($urandom));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    in_byte_valid = 0;
    rst_n = 0;
    #1;
    check({tag, "_rst_ov"}, out_valid, 0);
    check({tag, "_rst_fe"}, frame_err, 0);
    check({tag, "_rst_type"}, msg_type, 0);
    check({tag, "_rst_payload"}, payload, 0);
    check({tag, "_rst_msgs"}, msg_count, 0);
    check({tag, "_rst_errs"}, err_count, 0);
    check({tag, "_rst_busy"}, busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int ov0, fe0, len, r;
    rst_n = 0; in_byte_valid = 0; in_byte = 0;
    ov_seen = 0; fe_seen = 0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset("init");

    // Contiguous 36-byte 'A' frame with body 0x01..0x23
    queue_frame(36, 8'h41, 1);
    flush(0);
    check("a_type", msg_type, 8'h41);
    check("a_first", payload[511:504], 8'h01);
    check("a_last", payload[239:232], 8'h23);
    check("a_tail_zero", payload[231:0], 0);
    check("a_count", msg_count, 1);

    // 23-byte 'X' frame with valid toggling
    ov0 = ov_seen;
    queue_frame(23, 8'h58, 0);
    flush(1);
    check("x_pulses", ov_seen - ov0, 1);
    check("x_type", msg_type, 8'h58);

    // Back-to-back 'D' then 'U'
    do_reset("b2b");
    ov0 = ov_seen;
    queue_frame(19, 8'h44, 0);
    flush(0);
    check("d_type", msg_type, 8'h44);
    queue_frame(35, 8'h55, 0);
    flush(0);
    check("u_type", msg_type, 8'h55);
    check("b2b_pulses", ov_seen - ov0, 2);
    check("b2b_count", msg_count, 2);

    // Oversize frame drained, then a good 'A'
    ov0 = ov_seen; fe0 = fe_seen;
    queue_frame(80, 8'h41, 0);
    flush(0);
    check("drain_fe", fe_seen - fe0, 1);
    check("drain_no_ov", ov_seen - ov0, 0);
    check("drain_errs", err_count, 1);
    queue_frame(36, 8'h41, 1);
    flush(0);
    check("post_drain_type", msg_type, 8'h41);
    check("post_drain_last", payload[239:232], 8'h23);

    // Zero-length frame, then a type-only 'D'
    fe0 = fe_seen;
    queue_frame(0, 8'h00, 0);
    queue_frame(1, 8'h44, 0);
    flush(0);
    check("zero_fe", fe_seen - fe0, 1);
    check("l1_type", msg_type, 8'h44);
    check("l1_payload", payload, 0);

    // Reset mid-frame, then a full 'X'
    queue_frame(36, 8'h41, 1);
    for (int i = 0; i < 10; i++) step(1'b1, tx_q.pop_front());
    tx_q.delete();
    do_reset("mid");
    queue_frame(23, 8'h58, 0);
    flush(0);
    check("mid_type", msg_type, 8'h58);
    check("mid_count", msg_count, 1);

    // Random stream including boundary lengths
    for (int f = 0; f < 200; f++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       len = 0;
        1:       len = $urandom_range(MAX_LEN + 1, 300);
        2:       len = MAX_LEN;
        3:       len = 1;
        4:       len = MAX_LEN + 1;
        default: len = $urandom_range(2, MAX_LEN);
      endcase
      queue_frame(len, 8'($urandom), 0);
      flush($urandom_range(0, 2));
    end
    repeat (3) step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/itch_frame_assembler.md
ITCH_FRAME_ASSEMBLER -- requirements
Module: itch_frame_assembler

Interface
REQ-001 SHALL have parameter MAX_MSG_LEN, default 64, giving the largest accepted message length in bytes, type byte included; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_byte_valid, input, 1 bit: in_byte is present this cycle. There is no backpressure; every valid byte is consumed.
REQ-005 SHALL have port in_byte, input, 8 bits: the framed byte stream.
REQ-006 SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a complete message. Wired to the dispatcher in_valid.
REQ-007 SHALL have port msg_type, output, 8 bits: the message type byte. Wired to the dispatcher msg_type.
REQ-008 SHALL have port payload, output, 512 bits: the message body after the type byte. Wired to the dispatcher payload.
REQ-009 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a framing error.
REQ-010 SHALL have port msg_count, output, 32 bits: count of messages emitted.
REQ-011 SHALL have port err_count, output, 16 bits: count of framing errors, saturating.
REQ-012 SHALL have port busy, output, 1 bit: high when the FSM is in any state other than LEN_HI.

Function
REQ-013 SHALL parse the stream as repeated frames: a 2-byte big-endian length L, then L message bytes. The first message byte is the type; the rest are body bytes.
REQ-014 SHALL implement FSM states LEN_HI, LEN_LO, TYPE, BODY, DRAIN. Transitions occur only on cycles with in_byte_valid=1; with in_byte_valid=0, state and all counters hold.
REQ-015 SHALL make these transitions:
- LEN_HI -> LEN_LO.
- LEN_LO with 1<=L<=MAX_MSG_LEN -> TYPE.
- LEN_LO with L=0 -> LEN_HI, with frame_err.
- LEN_LO with L>MAX_MSG_LEN -> DRAIN, with frame_err.
- TYPE with L=1 -> LEN_HI, emitting the message.
- TYPE with L>1 -> BODY.
- BODY after the (L-1)th body byte -> LEN_HI, emitting the message.
- DRAIN after L bytes consumed -> LEN_HI.
REQ-016 SHALL clear the internal payload shift register to zero when the TYPE byte is accepted.
REQ-017 SHALL place body byte k (k=0 first) at payload[511-8k -: 8]. Unfilled bytes SHALL be zero.
REQ-018 SHALL assert out_valid for exactly one cycle, in the cycle after the last message byte is accepted (latency 1).
REQ-019 SHALL update msg_type and payload only together with out_valid. Both SHALL hold stable until the next out_valid.
REQ-020 SHALL assert frame_err for exactly one cycle, in the cycle after the LEN_LO byte is accepted. frame_err and out_valid SHALL never be high together.
REQ-021 SHALL produce no out_valid for a drained frame. Bytes arriving in DRAIN SHALL count toward L and SHALL NOT be interpreted.
REQ-022 SHALL track position with an internal byte counter of at least 16 bits so that L up to 65535 drains correctly.
REQ-023 SHALL allow back-to-back frames: the LEN_HI byte of the next frame may arrive in the cycle immediately after a message's last byte. This cycle SHALL coincide with out_valid with no byte loss.
REQ-024 SHALL increment msg_count by 1 per out_valid, wrapping at 2^32.
REQ-025 SHALL increment err_count by 1 per frame_err, saturating at 16'hFFFF.

Reset
REQ-026 SHALL, when rst_n=0, immediately force the state to LEN_HI and drive the following outputs to zero: out_valid, frame_err, msg_type, payload, msg_count, err_count, busy.
REQ-027 SHALL discard any partial frame when rst_n is asserted mid-frame. After release, the first valid byte SHALL be treated as LEN_HI.

Verification
REQ-028 SHALL cover this scenario: frame 00 24 'A' plus 35 body bytes (0x01..0x23), contiguous.
- out_valid=1 one cycle after the last byte.
- msg_type=8'h41; payload[511:504]=8'h01 and payload[239:232]=8'h23.
- payload[231:0]=0; msg_count=1.
REQ-029 SHALL cover this scenario: frame 00 17 'X' (23 bytes) with in_byte_valid toggled 1,0,1,0.
- Exactly one out_valid, after the 23rd message byte.
- msg_type=8'h58; no early pulse.
REQ-030 SHALL cover this scenario: back-to-back 'D' (L=19) then 'U' (L=35) with no idle cycles.
- Two out_valid pulses, the first with msg_type=8'h44 and the second with msg_type=8'h55.
- msg_count=2.
REQ-031 SHALL cover this scenario: frame 00 50 (L=80) followed by 80 bytes, then a valid 'A' frame.
- frame_err pulses once; err_count=1; no out_valid for the bad frame.
- The 'A' frame is emitted correctly.
REQ-032 SHALL cover this scenario: frame 00 00, then 00 01 'D'.
- frame_err pulses once.
- Then out_valid with msg_type=8'h44 and payload=0.
REQ-033 SHALL cover this scenario: rst_n pulsed low after 10 bytes of an 'A' frame, then a full 'X' frame.
- All outputs read 0 during reset.
- The 'X' frame is emitted; msg_count=1.
